// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: NEC-style IR frame decoder (leader, 32 data bits, repeat).
// Ports: clk_pixel_in/rst_in (sync, active-high), ir_in raw pin;
//   decoded_ir_out held code, decoded_ir_out_valid / repeat_out / error_out strobes.
module ir_nec_decoder #(
  parameter int CYCLES_PER_US = 74,
  parameter int GLITCH_US     = 20,
  parameter bit IR_ACTIVE_LOW = 1'b1,
  parameter bit CHECK_INVERSE = 1'b0
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic        ir_in,
  output logic [31:0] decoded_ir_out,
  output logic        decoded_ir_out_valid,
  output logic        repeat_out,
  output logic        error_out
);

  localparam int FILT_CYC = GLITCH_US * CYCLES_PER_US;
  localparam int FW_RAW   = $clog2(FILT_CYC + 1);
  localparam int FW       = (FW_RAW > 0) ? FW_RAW : 1;
  localparam int PW_RAW   = $clog2(CYCLES_PER_US);
  localparam int PW       = (PW_RAW > 0) ? PW_RAW : 1;
  localparam logic IDLE_LVL = IR_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYCLES_PER_US - 1);
  localparam logic [13:0]   US_SAT    = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_REP_MARK,
    S_TRAIL
  } state_t;

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_filt_q;
  logic [FW-1:0] r_gcnt;
  logic [PW-1:0] r_pre;
  logic [13:0]   r_us;

  state_t        r_state;
  logic [4:0]    r_bit_idx;
  logic [31:0]   r_word;
  logic [31:0]   r_code;
  logic          r_valid;
  logic          r_rep;
  logic          r_err;

  logic          w_raw_mark;
  logic          w_edge;
  logic          w_mark_start;
  logic          w_mark_end;
  logic [13:0]   w_max;
  logic          w_timeout;
  logic          w_bit0;
  logic          w_bit1;
  logic [31:0]   w_shift;
  logic          w_inv_ok;

  state_t        w_state_nxt;
  logic [4:0]    w_idx_nxt;
  logic [31:0]   w_word_nxt;
  logic [31:0]   w_code_nxt;
  logic          w_valid_nxt;
  logic          w_rep_nxt;
  logic          w_err_nxt;

  function automatic logic in_win(
    input logic [13:0] w,
    input logic [13:0] lo,
    input logic [13:0] hi
  );
    return (w >= lo) && (w <= hi);
  endfunction

  assign w_raw_mark   = IR_ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
  assign w_edge       = r_filt ^ r_filt_q;
  assign w_mark_start = w_edge & r_filt;
  assign w_mark_end   = w_edge & ~r_filt;

  // Sync flops reset to the idle pin level so no edge is seen after reset.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_sync   <= {2{IDLE_LVL}};
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
      r_gcnt   <= '0;
    end else begin
      r_sync   <= {r_sync[0], ir_in};
      r_filt_q <= r_filt;
      if (w_raw_mark == r_filt) begin
        r_gcnt <= '0;
      end else if (r_gcnt == FILT_LAST) begin
        r_filt <= w_raw_mark;
        r_gcnt <= '0;
      end else begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in || w_edge) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      if (r_us != US_SAT) begin
        r_us <= r_us + 14'd1;
      end
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_max = US_SAT;
    case (r_state)
      S_LEAD_MARK:  w_max = 14'd11250;
      S_LEAD_SPACE: w_max = 14'd5625;
      S_BIT_MARK:   w_max = 14'd725;
      S_BIT_SPACE:  w_max = 14'd2110;
      S_REP_MARK:   w_max = 14'd725;
      S_TRAIL:      w_max = 14'd725;
      default:      w_max = US_SAT;
    endcase
  end

  assign w_timeout = (r_state != S_IDLE) && (r_us > w_max);
  assign w_bit0    = in_win(r_us, 14'd400, 14'd725);
  assign w_bit1    = in_win(r_us, 14'd1265, 14'd2110);
  assign w_shift   = {w_bit1, r_word[31:1]};
  assign w_inv_ok  = (w_shift[15:8] == ~w_shift[7:0]) &&
                     (w_shift[31:24] == ~w_shift[23:16]);

  // A timeout overrides any edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_bit_idx;
    w_word_nxt  = r_word;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_rep_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = (r_state != S_TRAIL);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mark_start) w_state_nxt = S_LEAD_MARK;
        end
        S_LEAD_MARK: begin
          if (w_mark_end) begin
            if (in_win(r_us, 14'd6750, 14'd11250)) begin
              w_state_nxt = S_LEAD_SPACE;
            end else begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
        S_LEAD_SPACE: begin
          if (w_mark_start) begin
            if (in_win(r_us, 14'd3375, 14'd5625)) begin
              w_state_nxt = S_BIT_MARK;
              w_idx_nxt   = 5'd0;
            end else if (in_win(r_us, 14'd1687, 14'd2812)) begin
              w_state_nxt = S_REP_MARK;
            end else begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
        S_BIT_MARK: begin
          if (w_mark_end) begin
            if (in_win(r_us, 14'd400, 14'd725)) begin
              w_state_nxt = S_BIT_SPACE;
            end else begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
        S_BIT_SPACE: begin
          if (w_mark_start) begin
            if (w_bit0 || w_bit1) begin
              w_word_nxt = w_shift;
              if (r_bit_idx == 5'd31) begin
                w_state_nxt = S_TRAIL;
                if (!CHECK_INVERSE || w_inv_ok) begin
                  w_code_nxt  = w_shift;
                  w_valid_nxt = 1'b1;
                end else begin
                  w_err_nxt = 1'b1;
                end
              end else begin
                w_idx_nxt   = r_bit_idx + 5'd1;
                w_state_nxt = S_BIT_MARK;
              end
            end else begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
        S_REP_MARK: begin
          if (w_mark_end) begin
            w_state_nxt = S_IDLE;
            if (in_win(r_us, 14'd400, 14'd725)) begin
              w_rep_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        S_TRAIL: begin
          if (w_mark_end) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_word    <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_rep     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_idx_nxt;
      r_word    <= w_word_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_rep     <= w_rep_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign decoded_ir_out       = r_code;
  assign decoded_ir_out_valid = r_valid;
  assign repeat_out           = r_rep;
  assign error_out            = r_err;

endmodule
